// File: rtl/ct_f_spsram_param_pkg.sv
// Shared SRAM definitions: init state encodings and read-valid pipeline depth.
package ct_f_spsram_param_pkg;

  // Init sequencer state encodings
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Array read latency without the optional output stage
  localparam int RD_PIPE_BASE = 1;

  // Total read-valid pipeline depth for a given output-register setting
  function automatic int rd_pipe_depth(input int out_reg);
    return RD_PIPE_BASE + ((out_reg != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/ct_f_spsram_init_ctrl.sv
// Post-reset clear sequencer and array access mux (init vs external port).
module ct_f_spsram_init_ctrl
  import ct_f_spsram_param_pkg::*;
#(
  parameter int            DW       = 7,
  parameter int            AW       = 9,
  parameter int            INIT_EN  = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          i_rst_b,
  input  logic [AW-1:0] i_addr,
  input  logic          i_cen,
  input  logic          i_gwen,
  input  logic [DW-1:0] i_wen,
  input  logic [DW-1:0] i_d,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_we,
  output logic          o_ram_re,
  output logic [DW-1:0] o_ram_din,
  output logic          o_busy,
  output logic          o_init_done
);

  // Counter is one bit wider than the address so the last word is reachable cleanly
  localparam logic [AW:0] LAST_WORD = {1'b0, {AW{1'b1}}};

  logic [0:0] r_state;
  logic [AW:0] r_cnt;
  logic        r_init_done;

  // Init sequencer: one word cleared per edge, READY after the last word
  always_ff @(posedge clk) begin
    if (!i_rst_b) begin
      r_state     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_WORD) begin
        r_state     <= ST_READY;
        r_init_done <= 1'b1;
      end
    end else begin
      r_init_done <= 1'b1;
    end
  end

  // Access mux: reset blocks everything, init owns the array, else the external port
  always_comb begin
    o_ram_addr = i_addr;
    o_ram_din  = i_d;
    o_ram_we   = '0;
    o_ram_re   = 1'b0;
    if (!i_rst_b) begin
      o_ram_we = '0;
      o_ram_re = 1'b0;
    end else if (r_state == ST_INIT) begin
      o_ram_addr = r_cnt[AW-1:0];
      o_ram_din  = INIT_VAL;
      o_ram_we   = '1;
    end else if (!i_cen) begin
      if (i_gwen) begin
        o_ram_re = 1'b1;
      end else begin
        o_ram_we = ~i_wen;
      end
    end
  end

  assign o_busy      = (r_state == ST_INIT);
  assign o_init_done = r_init_done;

endmodule

// File: rtl/fpga_ram.sv
// Generic single-port block RAM primitive with registered read port.
module fpga_ram #(
  parameter int DW = 1,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_dout;

  // Write port and registered read port; dout only moves on a read
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    if (i_re) begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM wrapper with init engine, optional output
// register and Q hold; storage is DW one-bit RAM slices.
module ct_f_spsram_param
  import ct_f_spsram_param_pkg::*;
#(
  parameter int            DW       = 7,
  parameter int            AW       = 9,
  parameter int            OUT_REG  = 0,
  parameter int            INIT_EN  = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST_B,
  input  logic [AW-1:0] A,
  input  logic          CEN,
  input  logic          GWEN,
  input  logic [DW-1:0] WEN,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          INIT_DONE
);

  localparam int RD_DEPTH = rd_pipe_depth(OUT_REG);

  logic [AW-1:0]       r_addr_hold;
  logic [AW-1:0]       w_ext_addr;
  logic [AW-1:0]       w_ram_addr;
  logic [DW-1:0]       w_ram_we;
  logic                w_ram_re;
  logic [DW-1:0]       w_ram_din;
  logic [DW-1:0]       w_ram_dout;
  logic                w_busy;
  logic [RD_DEPTH-1:0] r_rd_vld;
  logic [DW-1:0]       w_stage_dout;
  logic                w_stage_vld;
  logic [DW-1:0]       r_q_hold;

  // Remember the last enabled address so a deselected array sees a stable address
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_addr_hold <= '0;
    end else if (!CEN) begin
      r_addr_hold <= A;
    end
  end

  assign w_ext_addr = CEN ? r_addr_hold : A;

  ct_f_spsram_init_ctrl #(
    .DW       (DW),
    .AW       (AW),
    .INIT_EN  (INIT_EN),
    .INIT_VAL (INIT_VAL)
  ) u_init_ctrl (
    .clk         (CLK),
    .i_rst_b     (RST_B),
    .i_addr      (w_ext_addr),
    .i_cen       (CEN),
    .i_gwen      (GWEN),
    .i_wen       (WEN),
    .i_d         (D),
    .o_ram_addr  (w_ram_addr),
    .o_ram_we    (w_ram_we),
    .o_ram_re    (w_ram_re),
    .o_ram_din   (w_ram_din),
    .o_busy      (w_busy),
    .o_init_done (INIT_DONE)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_bit
      fpga_ram #(
        .DW (1),
        .AW (AW)
      ) u_ram (
        .clk    (CLK),
        .i_we   (w_ram_we[gi]),
        .i_re   (w_ram_re),
        .i_addr (w_ram_addr),
        .i_din  (w_ram_din[gi]),
        .o_dout (w_ram_dout[gi])
      );
    end
  endgenerate

  // Read-valid shift: bit 0 marks fresh array data, top bit marks data at the output stage
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_rd_vld <= '0;
    end else begin
      r_rd_vld <= RD_DEPTH'({r_rd_vld, w_ram_re});
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_q_pipe;

      // Extra output stage captures array data one cycle after it is read
      always_ff @(posedge CLK) begin
        if (!RST_B) begin
          r_q_pipe <= '0;
        end else if (r_rd_vld[0]) begin
          r_q_pipe <= w_ram_dout;
        end
      end

      assign w_stage_dout = r_q_pipe;
    end else begin : g_noreg
      assign w_stage_dout = w_ram_dout;
    end
  endgenerate

  assign w_stage_vld = r_rd_vld[RD_DEPTH-1];

  // Hold the last read data so writes and idle cycles never move Q
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_q_hold <= '0;
    end else if (w_stage_vld) begin
      r_q_hold <= w_stage_dout;
    end
  end

  assign Q = w_busy ? '0 : (w_stage_vld ? w_stage_dout : r_q_hold);

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Self-checking bench: three wrapper variants driven in lockstep and compared
// each cycle against an array/queue reference model, plus directed vectors.
module tb_ct_f_spsram_param;

  localparam int DW    = 7;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int ND    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_b;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [DW-1:0] wen;
  logic [DW-1:0] d;
  logic [DW-1:0] q    [ND];
  logic          done [ND];

  // Variant 0: defaults. Variant 1: output register + nonzero init value. Variant 2: no init.
  ct_f_spsram_param #(.DW(DW), .AW(AW), .OUT_REG(0), .INIT_EN(1), .INIT_VAL(7'h00)) u_dut0 (
    .CLK(clk), .RST_B(rst_b), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
    .Q(q[0]), .INIT_DONE(done[0]));
  ct_f_spsram_param #(.DW(DW), .AW(AW), .OUT_REG(1), .INIT_EN(1), .INIT_VAL(7'h2A)) u_dut1 (
    .CLK(clk), .RST_B(rst_b), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
    .Q(q[1]), .INIT_DONE(done[1]));
  ct_f_spsram_param #(.DW(DW), .AW(AW), .OUT_REG(0), .INIT_EN(0), .INIT_VAL(7'h00)) u_dut2 (
    .CLK(clk), .RST_B(rst_b), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
    .Q(q[2]), .INIT_DONE(done[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            lat_c  [ND] = '{1, 2, 1};
  int            inen_c [ND] = '{1, 1, 0};
  logic [DW-1:0] ival_c [ND] = '{7'h00, 7'h2A, 7'h00};
  logic [DW-1:0] mem    [ND][DEPTH];
  logic [DW-1:0] kmask  [ND][DEPTH];
  logic [DW-1:0] q_exp  [ND];
  logic [DW-1:0] q_msk  [ND];
  logic          pv     [ND];
  logic [DW-1:0] pd     [ND];
  logic [DW-1:0] pm     [ND];
  logic          done_exp [ND];
  int            prior = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic          chk;
    logic [DW-1:0] exp_q;
  } vec_t;

  vec_t vt [13];

  task automatic cmp_bit(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_q(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp, input logic [DW-1:0] msk);
    n_cmp++;
    if (((got ^ exp) & msk) !== '0) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h mask=%h t=%0t", nm, got, exp, msk, $time);
    end
  endtask

  // Behavioural effect of one clock edge, written from the access rules:
  // memory is a plain array, reads queue their data for the variant's latency.
  task automatic model_edge();
    if (!rst_b) begin
      prior = 0;
      for (int k = 0; k < ND; k++) begin
        q_exp[k] = '0; q_msk[k] = '1; pv[k] = 1'b0; done_exp[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < ND; k++) begin
        bit acc, rd, wr;
        acc = (inen_c[k] == 0) || (prior >= DEPTH);
        if (inen_c[k] != 0 && prior == DEPTH - 1) begin
          for (int w = 0; w < DEPTH; w++) begin
            mem[k][w] = ival_c[k]; kmask[k][w] = '1;
          end
        end
        rd = acc && !cen && gwen;
        wr = acc && !cen && !gwen;
        if (lat_c[k] == 1) begin
          if (rd) begin q_exp[k] = mem[k][a]; q_msk[k] = kmask[k][a]; end
        end else begin
          if (pv[k]) begin q_exp[k] = pd[k]; q_msk[k] = pm[k]; end
          pv[k] = rd;
          if (rd) begin pd[k] = mem[k][a]; pm[k] = kmask[k][a]; end
        end
        if (wr) begin
          for (int b = 0; b < DW; b++) begin
            if (!wen[b]) begin mem[k][a][b] = d[b]; kmask[k][a][b] = 1'b1; end
          end
        end
      end
      prior++;
      for (int k = 0; k < ND; k++) begin
        done_exp[k] = (inen_c[k] != 0) ? (prior >= DEPTH) : (prior >= 1);
      end
    end
  endtask

  // One clock cycle: drive, clock, update model, sample and compare all variants
  task automatic step(input logic rb, input logic [AW-1:0] ai, input logic ci,
                      input logic gwi, input logic [DW-1:0] wi, input logic [DW-1:0] di);
    rst_b = rb; a = ai; cen = ci; gwen = gwi; wen = wi; d = di;
    if (rb && !ci)
      $display("txn t=%0t a=%h %s wen=%h d=%h", $time, ai, gwi ? "rd" : "wr", wi, di);
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < ND; k++) begin
      cmp_bit($sformatf("model_done%0d", k), done[k], done_exp[k]);
      cmp_q($sformatf("model_q%0d", k), q[k], q_exp[k], q_msk[k]);
    end
  endtask

  task automatic idle();
    logic [AW-1:0] ra;
    ra = AW'($urandom);
    step(1'b1, ra, 1'b1, 1'b1, '1, '0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rw, rdat;
    logic          rc, rg;

    for (int k = 0; k < ND; k++)
      for (int w = 0; w < DEPTH; w++) kmask[k][w] = '0;

    vt[0]  = '{9'h1A3, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b0, 7'h00};
    vt[1]  = '{9'h000, 1'b1, 1'b1, 7'h7F, 7'h00, 1'b1, 7'h00};
    vt[2]  = '{9'h1FF, 1'b0, 1'b0, 7'h00, 7'h55, 1'b0, 7'h00};
    vt[3]  = '{9'h1FF, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b0, 7'h00};
    vt[4]  = '{9'h000, 1'b1, 1'b1, 7'h7F, 7'h00, 1'b1, 7'h55};
    vt[5]  = '{9'h010, 1'b0, 1'b0, 7'h00, 7'h7F, 1'b1, 7'h55};
    vt[6]  = '{9'h010, 1'b0, 1'b0, 7'h70, 7'h00, 1'b1, 7'h55};
    vt[7]  = '{9'h010, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b0, 7'h00};
    vt[8]  = '{9'h1FF, 1'b1, 1'b1, 7'h7F, 7'h00, 1'b1, 7'h70};
    vt[9]  = '{9'h010, 1'b1, 1'b0, 7'h00, 7'h00, 1'b1, 7'h70};
    vt[10] = '{9'h010, 1'b0, 1'b1, 7'h00, 7'h00, 1'b1, 7'h70};
    vt[11] = '{9'h010, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b0, 7'h00};
    vt[12] = '{9'h1FF, 1'b1, 1'b1, 7'h7F, 7'h00, 1'b1, 7'h70};

    // Reset
    rst_b = 1'b0; a = '0; cen = 1'b1; gwen = 1'b1; wen = '1; d = '0;
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, '1, '0);
    cmp_bit("rst_done", done[0], 1'b0);
    cmp_q("rst_q", q[0], 7'h00, '1);

    // Start init, try a write at cycle 5, reset at cycle 100
    for (int e = 1; e <= 100; e++) begin
      if (e == 5) begin
        step(1'b1, 9'h000, 1'b0, 1'b0, 7'h00, 7'h3C);
        cmp_q("init_wr_ignored_q", q[0], 7'h00, '1);
      end else begin
        idle();
      end
    end
    step(1'b0, '0, 1'b1, 1'b1, '1, '0);
    cmp_bit("midrst_done", done[0], 1'b0);
    cmp_q("midrst_q", q[0], 7'h00, '1);
    cmp_bit("midrst_done_noinit", done[2], 1'b0);

    // Full init after release
    for (int e = 1; e <= DEPTH; e++) begin
      if (e == 5) step(1'b1, 9'h000, 1'b0, 1'b0, 7'h00, 7'h3C);
      else idle();
      cmp_q("init_q", q[0], 7'h00, '1);
      if (e == 1)         cmp_bit("noinit_done_e1", done[2], 1'b1);
      if (e == DEPTH - 1) cmp_bit("done_e511", done[0], 1'b0);
      if (e == DEPTH) begin
        cmp_bit("done_e512", done[0], 1'b1);
        cmp_bit("done_e512_oreg", done[1], 1'b1);
      end
    end

    // Word 0 must hold the init value, not the ignored write
    step(1'b1, 9'h000, 1'b0, 1'b1, '1, '0);
    idle();
    cmp_q("rd0_q", q[0], 7'h00, '1);
    cmp_q("rd0_q_oreg", q[1], 7'h2A, '1);

    // Every sampled address on the init-value variant reads the init value
    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom);
      step(1'b1, ra, 1'b0, 1'b1, '1, '0);
      cmp_q("initval_q", q[1], 7'h2A, '1);
      cmp_q("initval0_q", q[0], 7'h00, '1);
    end
    idle();

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      step(1'b1, vt[i].a, vt[i].cen, vt[i].gwen, vt[i].wen, vt[i].d);
      if (vt[i].chk) cmp_q($sformatf("vec%0d_q", i), q[0], vt[i].exp_q, '1);
    end

    // Q hold across deselected cycles and a write to the last-read address
    step(1'b1, 9'h1FF, 1'b0, 1'b1, '1, '0);
    idle();
    cmp_q("hold_rd_q", q[0], 7'h55, '1);
    for (int i = 0; i < 10; i++) begin
      ra = AW'($urandom); rw = DW'($urandom); rdat = DW'($urandom); rg = 1'($urandom);
      step(1'b1, ra, 1'b1, rg, rw, rdat);
      cmp_q("hold_cen1_q", q[0], 7'h55, '1);
    end
    step(1'b1, 9'h1FF, 1'b0, 1'b0, 7'h00, 7'h0F);
    cmp_q("hold_wr_q", q[0], 7'h55, '1);
    step(1'b1, 9'h1FF, 1'b0, 1'b1, '1, '0);
    idle();
    cmp_q("hold_new_q", q[0], 7'h0F, '1);

    // Randomised traffic on a small address window to get frequent hits
    for (int i = 0; i < 2000; i++) begin
      ra   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      rc   = ($urandom_range(0, 3) == 0);
      rg   = 1'($urandom);
      rw   = ($urandom_range(0, 1) == 0) ? 7'h00 : DW'($urandom);
      rdat = DW'($urandom);
      step(1'b1, ra, rc, rg, rw, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
